// File: rtl/prog_loader.sv
// Serial program loader: receives START/LEN/payload/CSUM frames, writes the
// payload into instruction memory and holds the CPU in reset until a frame verifies.
module prog_loader #(
    parameter logic [7:0]  START_BYTE = 8'hA5,
    parameter logic [7:0]  BASE_ADDR  = 8'h00,
    parameter logic [15:0] TIMEOUT    = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       mem_we,
    output logic       cpu_hold,
    output logic       load_done,
    output logic       load_err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_RUN  = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic        rx_ready_reg;
    logic [7:0]  mem_addr_reg,  mem_addr_next;
    logic [7:0]  mem_wdata_reg, mem_wdata_next;
    logic        mem_we_reg,    mem_we_next;
    logic        cpu_hold_reg,  cpu_hold_next;
    logic        load_done_reg, load_done_next;
    logic        load_err_reg,  load_err_next;

    logic [8:0]  count_reg, count_next;
    logic [7:0]  addr_reg,  addr_next;
    logic [7:0]  sum_reg,   sum_next;
    logic [15:0] timer_reg, timer_next;

    logic accept;
    logic in_frame;
    logic timed_out;
    logic is_start;
    logic last_byte;
    logic csum_ok;

    assign accept    = rx_valid && rx_ready_reg;
    assign in_frame  = (state_reg == S_LEN) || (state_reg == S_DATA) || (state_reg == S_CSUM);
    // The timer counts idle cycles already spent; the cycle that would make it
    // reach TIMEOUT aborts the frame instead.
    assign timed_out = in_frame && !accept && (timer_reg == (TIMEOUT - 16'd1));
    assign is_start  = (rx_data == START_BYTE);
    assign last_byte = (count_reg == 9'd1);
    assign csum_ok   = (rx_data == sum_reg);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept && is_start) begin
                    state_next = S_LEN;
                end
            end
            S_LEN: begin
                if (accept) begin
                    state_next = S_DATA;
                end else if (timed_out) begin
                    state_next = S_IDLE;
                end
            end
            S_DATA: begin
                if (accept && last_byte) begin
                    state_next = S_CSUM;
                end else if (timed_out) begin
                    state_next = S_IDLE;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_next = csum_ok ? S_RUN : S_IDLE;
                end else if (timed_out) begin
                    state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (accept && is_start) begin
                    state_next = S_LEN;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output and datapath next-value logic
    always_comb begin
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_we_next    = 1'b0;
        cpu_hold_next  = cpu_hold_reg;
        load_done_next = 1'b0;
        load_err_next  = load_err_reg;
        count_next     = count_reg;
        addr_next      = addr_reg;
        sum_next       = sum_reg;
        timer_next     = 16'd0;

        if (in_frame && !accept && !timed_out) begin
            timer_next = timer_reg + 16'd1;
        end

        case (state_reg)
            S_IDLE: begin
                if (accept && is_start) begin
                    load_err_next = 1'b0;
                    cpu_hold_next = 1'b1;
                end
            end
            S_LEN: begin
                if (accept) begin
                    count_next = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    addr_next  = BASE_ADDR;
                    sum_next   = 8'd0;
                end
            end
            S_DATA: begin
                if (accept) begin
                    mem_we_next    = 1'b1;
                    mem_addr_next  = addr_reg;
                    mem_wdata_next = rx_data;
                    addr_next      = addr_reg + 8'd1;
                    sum_next       = sum_reg + rx_data;
                    count_next     = count_reg - 9'd1;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (csum_ok) begin
                        load_done_next = 1'b1;
                        cpu_hold_next  = 1'b0;
                    end else begin
                        load_err_next  = 1'b1;
                        cpu_hold_next  = 1'b1;
                    end
                end
            end
            S_RUN: begin
                cpu_hold_next = 1'b0;
                if (accept && is_start) begin
                    cpu_hold_next = 1'b1;
                end
            end
            default: ;
        endcase

        // An aborted frame keeps the CPU held; partially written memory stays
        // but is never executed.
        if (timed_out) begin
            load_err_next = 1'b1;
            cpu_hold_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ready_reg  <= 1'b0;
            mem_addr_reg  <= BASE_ADDR;
            mem_wdata_reg <= 8'd0;
            mem_we_reg    <= 1'b0;
            cpu_hold_reg  <= 1'b1;
            load_done_reg <= 1'b0;
            load_err_reg  <= 1'b0;
            count_reg     <= 9'd0;
            addr_reg      <= BASE_ADDR;
            sum_reg       <= 8'd0;
            timer_reg     <= 16'd0;
        end else begin
            rx_ready_reg  <= 1'b1;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_we_reg    <= mem_we_next;
            cpu_hold_reg  <= cpu_hold_next;
            load_done_reg <= load_done_next;
            load_err_reg  <= load_err_next;
            count_reg     <= count_next;
            addr_reg      <= addr_next;
            sum_reg       <= sum_next;
            timer_reg     <= timer_next;
        end
    end

    assign rx_ready  = rx_ready_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_we    = mem_we_reg;
    assign cpu_hold  = cpu_hold_reg;
    assign load_done = load_done_reg;
    assign load_err  = load_err_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus queues expected writes/done pulses,
// a negedge monitor pops and compares them as the DUT emits them.
module tb_prog_loader;

    localparam logic [15:0] TO = 16'd1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    prog_loader #(
        .START_BYTE(8'hA5),
        .BASE_ADDR (8'h00),
        .TIMEOUT   (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_we   (mem_we),
        .cpu_hold (cpu_hold),
        .load_done(load_done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_done;
        logic [7:0] a;
        logic [7:0] d;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   we_run = 0;
    int   we_run_max = 0;

    // Monitor: outputs are registered, so the falling edge is a stable sample point.
    always @(negedge clk) begin
        exp_t e;
        if (mem_we) begin
            we_run = we_run + 1;
            if (we_run > we_run_max) we_run_max = we_run;
            total = total + 1;
            if (q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_write got addr=%h data=%h want none", mem_addr, mem_wdata);
            end else begin
                e = q.pop_front();
                if (e.is_done || mem_addr !== e.a || mem_wdata !== e.d) begin
                    bad = bad + 1;
                    $display("FAIL write got addr=%h data=%h want done=%0d addr=%h data=%h",
                             mem_addr, mem_wdata, e.is_done, e.a, e.d);
                end else begin
                    $display("write   addr=%h data=%h ok", mem_addr, mem_wdata);
                end
            end
        end else begin
            we_run = 0;
        end
        if (load_done) begin
            total = total + 1;
            if (q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_load_done got 1 want 0");
            end else begin
                e = q.pop_front();
                if (!e.is_done) begin
                    bad = bad + 1;
                    $display("FAIL load_done got done want write addr=%h data=%h", e.a, e.d);
                end else begin
                    $display("done    pulse ok");
                end
            end
        end
    end

    task automatic exp_w(input logic [7:0] a, input logic [7:0] d);
        exp_t e;
        e.is_done = 1'b0; e.a = a; e.d = d;
        q.push_back(e);
    endtask

    task automatic exp_d();
        exp_t e;
        e.is_done = 1'b1; e.a = 8'h00; e.d = 8'h00;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end else begin
            $display("check   %s = %0h ok", name, act);
        end
    endtask

    // Present one byte from a falling edge and hold it until a rising edge accepts it.
    task automatic send(input logic [7:0] b, input int gap);
        bit acc;
        int tries;
        acc = 1'b0;
        tries = 0;
        do begin
            @(negedge clk);
            rx_data  = b;
            rx_valid = 1'b1;
            acc = rx_ready;
            @(posedge clk);
            tries++;
        end while (!acc && tries < 20);
        if (!acc) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL send_ready byte=%h got rx_ready=0 want 1", b);
        end
        if (gap > 0) begin
            @(negedge clk);
            rx_valid = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cpu_hold", cpu_hold, 1);
        check("rst_mem_we", mem_we, 0);
        check("rst_load_done", load_done, 0);
        check("rst_load_err", load_err, 0);
        check("rst_mem_addr", mem_addr, 8'h00);
        check("rst_mem_wdata", mem_wdata, 8'h00);
        check("rst_rx_ready", rx_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rx_ready_rise", rx_ready, 1);

        // Good 3-byte frame, back-to-back
        we_run_max = 0;
        exp_w(8'h00, 8'h11); exp_w(8'h01, 8'h22); exp_w(8'h02, 8'h33); exp_d();
        send(8'hA5, 0); send(8'h03, 0); send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h66, 0);
        idle(3);
        check("t1_b2b_run", we_run_max, 3);
        check("t1_cpu_hold", cpu_hold, 0);
        check("t1_load_err", load_err, 0);
        check("t1_drained", q.size(), 0);

        // Bad checksum, then a good frame clears the error
        exp_w(8'h00, 8'h10); exp_w(8'h01, 8'h20);
        send(8'hA5, 0); send(8'h02, 0); send(8'h10, 0); send(8'h20, 0); send(8'h31, 0);
        idle(3);
        check("t2_load_err", load_err, 1);
        check("t2_cpu_hold", cpu_hold, 1);
        check("t2_drained", q.size(), 0);
        exp_w(8'h00, 8'h7E); exp_d();
        send(8'hA5, 0); send(8'h01, 0); send(8'h7E, 0); send(8'h7E, 0);
        idle(3);
        check("t2_err_cleared", load_err, 0);
        check("t2_cpu_released", cpu_hold, 0);

        // Leading junk in IDLE, 5-cycle gaps
        do_reset();
        exp_w(8'h00, 8'h7E); exp_d();
        send(8'h00, 5); send(8'hFF, 5); send(8'hA5, 5); send(8'h01, 5); send(8'h7E, 5); send(8'h7E, 5);
        idle(3);
        check("t3_cpu_hold", cpu_hold, 0);
        check("t3_load_err", load_err, 0);
        check("t3_drained", q.size(), 0);

        // Timeout mid-DATA
        exp_w(8'h00, 8'h01); exp_w(8'h01, 8'h02);
        send(8'hA5, 0); send(8'h04, 0); send(8'h01, 0); send(8'h02, 0);
        idle(int'(TO) - 6);
        check("t4_err_before_timeout", load_err, 0);
        repeat (10) @(negedge clk);
        check("t4_err_after_timeout", load_err, 1);
        check("t4_cpu_hold", cpu_hold, 1);
        check("t4_drained", q.size(), 0);

        // 256-byte frame wrapping the address
        for (int i = 0; i < 256; i++) exp_w(i[7:0], 8'h01);
        exp_d();
        send(8'hA5, 0); send(8'h00, 0);
        for (int i = 0; i < 256; i++) send(8'h01, 0);
        send(8'h00, 0);
        idle(3);
        check("t5_last_addr", mem_addr, 8'hFF);
        check("t5_cpu_hold", cpu_hold, 0);
        check("t5_load_err", load_err, 0);
        check("t5_drained", q.size(), 0);

        // Reset mid-DATA, fresh load, then reload from RUN
        exp_w(8'h00, 8'hAA); exp_w(8'h01, 8'hBB);
        send(8'hA5, 0); send(8'h04, 0); send(8'hAA, 0); send(8'hBB, 0);
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6_mem_we", mem_we, 0);
        check("t6_cpu_hold", cpu_hold, 1);
        check("t6_load_err", load_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_drained_at_reset", q.size(), 0);
        exp_w(8'h00, 8'h5A); exp_d();
        send(8'hA5, 0); send(8'h01, 0); send(8'h5A, 0); send(8'h5A, 0);
        idle(3);
        check("t6_cpu_released", cpu_hold, 0);
        send(8'hA5, 0);
        #1;
        check("t6_reload_hold", cpu_hold, 1);
        idle(3);
        check("t6_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
